// File: rtl/mux_scan_pkg.sv
// Shared widths, state encoding and parity helper for the mux8_1 scan serializer.
package mux_scan_pkg;
   localparam int SEL_W  = 3;
   localparam int WORD_W = 8;
   localparam int DIV_W  = 8;

   localparam logic [SEL_W-1:0] SEL_LAST = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_PAR  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic even_parity(input logic [WORD_W-1:0] word);
      return ^word;
   endfunction
endpackage

// File: rtl/mux8_1.sv
// 8:1 selector; {a,b,c} = n routes d(n+1) to e, a is the select MSB.
module mux8_1 (
   input  logic d1,
   input  logic d2,
   input  logic d3,
   input  logic d4,
   input  logic d5,
   input  logic d6,
   input  logic d7,
   input  logic d8,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic e
);
   always_comb begin
      e = 1'b0;
      case ({a, b, c})
         3'd0: e = d1;
         3'd1: e = d2;
         3'd2: e = d3;
         3'd3: e = d4;
         3'd4: e = d5;
         3'd5: e = d6;
         3'd6: e = d7;
         3'd7: e = d8;
         default: e = 1'b0;
      endcase
   end
endmodule

// File: rtl/mux8_scan_serializer.sv
// Parallel-to-serial front end driving mux8_1 select lines, LSB first, DIV cycles per bit.
// Optional even-parity ninth bit when MUX_SCAN_PARITY_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | load_ready high, waiting for load_valid to capture din
//   SEND    | select counter steps 0..7, mux output on ser_out
//   PAR     | even-parity bit on ser_out for DIV cycles (parity builds only)
//   DONE    | one-cycle done pulse, then back to IDLE
module mux8_scan_serializer
   import mux_scan_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] din,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              busy,
   output logic              done
);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [WORD_W-1:0]  data_q, data_d;
   logic               div_wrap;
   logic               mux_e;

   assign div_wrap   = (div_q == DIV_LAST);
   assign load_ready = (state_q == ST_IDLE) && !rst;
   assign a          = sel_q[2];
   assign b          = sel_q[1];
   assign c          = sel_q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         div_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         div_q   <= div_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      div_d   = div_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (load_valid && load_ready) begin
               data_d  = din;
               sel_d   = '0;
               div_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (div_wrap) begin
               div_d = '0;
               // select holds at 7 after the last bit so it never wraps mid-frame
               if (sel_q == SEL_LAST) begin
`ifdef MUX_SCAN_PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  sel_d = sel_q + SEL_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`ifdef MUX_SCAN_PARITY_EN
         ST_PAR: begin
            if (div_wrap) begin
               div_d   = '0;
               state_d = ST_DONE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   mux8_1 u_mux (
      .d1 (data_q[0]),
      .d2 (data_q[1]),
      .d3 (data_q[2]),
      .d4 (data_q[3]),
      .d5 (data_q[4]),
      .d6 (data_q[5]),
      .d7 (data_q[6]),
      .d8 (data_q[7]),
      .a  (sel_q[2]),
      .b  (sel_q[1]),
      .c  (sel_q[0]),
      .e  (mux_e)
   );

   always_comb begin
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_SEND: begin
            ser_out   = mux_e;
            ser_valid = 1'b1;
            busy      = 1'b1;
         end
`ifdef MUX_SCAN_PARITY_EN
         ST_PAR: begin
            ser_out   = even_parity(data_q);
            ser_valid = 1'b1;
            busy      = 1'b1;
         end
`endif
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mux8_scan_serializer.sv
// Scoreboard bench for mux8_scan_serializer: lane 0 runs DIV=1, lane 1 runs DIV=3.
module tb_mux8_scan_serializer;
`ifdef MUX_SCAN_PARITY_EN
   localparam int NBITS = 9;
`else
   localparam int NBITS = 8;
`endif

   typedef struct {
      int         lane;
      logic       bit_v;
      logic [2:0] sel;
      bit         chk_sel;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst        [2];
   logic [7:0] din        [2];
   logic       load_valid [2];
   logic       load_ready [2];
   logic       a_s        [2];
   logic       b_s        [2];
   logic       c_s        [2];
   logic       ser_out    [2];
   logic       ser_valid  [2];
   logic       busy       [2];
   logic       done       [2];

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sq[$];

   int base      [2];
   int last_base [2];
   bit active    [2];
   bit held      [2];
   bit have_prev [2];
   bit prev_rst  [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mux8_scan_serializer #(.DIV(1)) u_dut0 (
      .clk(clk), .rst(rst[0]), .din(din[0]), .load_valid(load_valid[0]),
      .load_ready(load_ready[0]), .a(a_s[0]), .b(b_s[0]), .c(c_s[0]),
      .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0])
   );

   mux8_scan_serializer #(.DIV(3)) u_dut1 (
      .clk(clk), .rst(rst[1]), .din(din[1]), .load_valid(load_valid[1]),
      .load_ready(load_ready[1]), .a(a_s[1]), .b(b_s[1]), .c(c_s[1]),
      .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1])
   );

   function automatic int div_of(input int lane);
      return (lane == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input int lane, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s lane%0d cyc%0d: got %0d expected %0d", name, lane, cyc, act, exp);
      end
   endtask

   // reference: a word accepted in cycle B shows bit n in cycles B+1+n*DIV .. B+(n+1)*DIV
   task automatic push_frame(input int lane, input logic [7:0] w);
      int d = div_of(lane);
      for (int n = 0; n < 8; n++)
         for (int r = 0; r < d; r++)
            sq.push_back('{lane: lane, bit_v: w[n], sel: 3'(n), chk_sel: 1'b1});
`ifdef MUX_SCAN_PARITY_EN
      for (int r = 0; r < d; r++)
         sq.push_back('{lane: lane, bit_v: ^w, sel: 3'd7, chk_sel: 1'b0});
`endif
   endtask

   task automatic flush_lane(input int lane);
      exp_t keep[$];
      foreach (sq[i]) if (sq[i].lane != lane) keep.push_back(sq[i]);
      sq = keep;
   endtask

   task automatic mon_lane(input int lane);
      int   d    = div_of(lane);
      int   last = base[lane] + NBITS * d;
      bit   exp_sv, exp_done, exp_ready;
      exp_t e;
      if (cyc == 0) begin
         prev_rst[lane] = rst[lane];
         return;
      end
      if (prev_rst[lane]) begin
         exp_ready = !rst[lane];
         chk("rst_sel", lane, int'({a_s[lane], b_s[lane], c_s[lane]}), 0);
         chk("rst_ser_out", lane, int'(ser_out[lane]), 0);
         chk("rst_ser_valid", lane, int'(ser_valid[lane]), 0);
         chk("rst_busy", lane, int'(busy[lane]), 0);
         chk("rst_done", lane, int'(done[lane]), 0);
         chk("rst_load_ready", lane, int'(load_ready[lane]), int'(exp_ready));
      end else begin
         exp_sv    = active[lane] && cyc >= base[lane] + 1 && cyc <= last;
         exp_done  = active[lane] && cyc == last + 1;
         exp_ready = !rst[lane] && !(active[lane] && cyc <= last + 1);
         chk("ser_valid", lane, int'(ser_valid[lane]), int'(exp_sv));
         chk("busy", lane, int'(busy[lane]), int'(exp_sv));
         chk("done", lane, int'(done[lane]), int'(exp_done));
         chk("load_ready", lane, int'(load_ready[lane]), int'(exp_ready));
         if (ser_valid[lane] || exp_sv) begin
            if (sq.size() == 0 || sq[0].lane != lane) begin
               n_cmp++;
               n_bad++;
               $display("FAIL stream_extra lane%0d cyc%0d: got unexpected serial bit %0d", lane, cyc, ser_out[lane]);
            end else begin
               e = sq.pop_front();
               if (ser_valid[lane]) begin
                  chk("ser_out", lane, int'(ser_out[lane]), int'(e.bit_v));
                  if (e.chk_sel)
                     chk("select", lane, int'({a_s[lane], b_s[lane], c_s[lane]}), int'(e.sel));
               end
            end
         end else begin
            chk("ser_out_idle", lane, int'(ser_out[lane]), 0);
         end
         if (active[lane] && cyc >= last + 1) active[lane] = 1'b0;
      end
      if (!load_valid[lane]) held[lane] = 1'b0;
      if (exp_ready && load_valid[lane]) begin
         if (held[lane] && have_prev[lane])
            chk("accept_gap", lane, cyc - last_base[lane], NBITS * d + 2);
         push_frame(lane, din[lane]);
         base[lane]      = cyc;
         last_base[lane] = cyc;
         have_prev[lane] = 1'b1;
         held[lane]      = 1'b1;
         active[lane]    = 1'b1;
      end
      if (rst[lane]) begin
         flush_lane(lane);
         active[lane]    = 1'b0;
         held[lane]      = 1'b0;
         have_prev[lane] = 1'b0;
      end
      prev_rst[lane] = rst[lane];
   endtask

   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) mon_lane(l);
   end

   task automatic wait_ready(input int lane);
      int t = 0;
      while (!load_ready[lane]) begin
         @(posedge clk); #1;
         t++;
         if (t > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout lane%0d cyc%0d: got load_ready 0 expected 1 within 200 cycles", lane, cyc);
            return;
         end
      end
   endtask

   task automatic do_reset(input int lane, input int n);
      rst[lane] = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
      rst[lane] = 1'b0;
   endtask

   task automatic send(input int lane, input logic [7:0] w);
      @(posedge clk); #1;
      din[lane] = w;
      load_valid[lane] = 1'b1;
      wait_ready(lane);
      @(posedge clk); #1;
      load_valid[lane] = 1'b0;
      din[lane] = 8'($urandom);
   endtask

   // valid stays high across two frames; din scrambled while the first is sent
   task automatic send_held(input int lane, input logic [7:0] w1, input logic [7:0] w2);
      int t = 0;
      @(posedge clk); #1;
      din[lane] = w1;
      load_valid[lane] = 1'b1;
      wait_ready(lane);
      @(posedge clk); #1;
      while (!load_ready[lane] && t < 200) begin
         din[lane] = 8'($urandom);
         @(posedge clk); #1;
         t++;
      end
      din[lane] = w2;
      @(posedge clk); #1;
      load_valid[lane] = 1'b0;
   endtask

   task automatic run_lane(input int lane);
      int d = div_of(lane);
      do_reset(lane, 3);
      send(lane, 8'h01);
      send(lane, 8'hA5);
      send_held(lane, 8'h3C, 8'hC3);
      send(lane, 8'hFF);
      repeat (4 * d) begin @(posedge clk); #1; end
      do_reset(lane, 2);
      send(lane, 8'h07);
      send(lane, 8'h03);
      for (int i = 0; i < 12; i++) begin
         send(lane, 8'($urandom));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      repeat (NBITS * d + 6) begin @(posedge clk); #1; end
   endtask

   initial begin
      for (int l = 0; l < 2; l++) begin
         rst[l] = 1'b1;
         din[l] = 8'h00;
         load_valid[l] = 1'b0;
         base[l] = 0;
         last_base[l] = 0;
         active[l] = 1'b0;
         held[l] = 1'b0;
         have_prev[l] = 1'b0;
         prev_rst[l] = 1'b1;
      end
      for (int l = 0; l < 2; l++) run_lane(l);
      chk("queue_drained", -1, sq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc%0d: got no end of test expected finish before time limit", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mux8_scan_serializer.md
# mux8_scan_serializer

Parallel-to-serial front end for the `mux8_1` 8:1 selector. It accepts an 8-bit word on a valid/ready handshake and holds it in a register. A select counter then steps `{a,b,c}` from 0 to 7 so the mux emits the word LSB-first as a serial bit stream. It sits directly upstream of `mux8_1` and owns the select lines and data inputs that the mux consumes.

## Interface
- `DIV`, default 1: clock cycles each serial bit is held; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  8  parallel word; `din[0]` is sent first.
- `load_valid`  in  1  producer offers `din`.
- `load_ready`  out  1  block can accept a word; high only in IDLE.
- `a`, `b`, `c`  out  1 each  select lines to `mux8_1`; `a` is the MSB, and `{a,b,c}` = n selects `d(n+1)`.
- `ser_out`  out  1  current serial bit.
- `ser_valid`  out  1  `ser_out` holds a payload or parity bit.
- `busy`  out  1  high in SEND and PAR.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SEND, PAR (only when parity is compiled in), DONE.
- IDLE:
  - `load_ready`=1.
  - When `load_valid && load_ready`, capture `din` into `data_q`, clear the select counter and the divider, and go to SEND.
- SEND:
  - `ser_out` = mux output for `{a,b,c}`; `ser_valid`=1.
  - The divider counts 0..DIV-1. On wrap, the select counter increments.
  - When the divider wraps with select = 7: go to PAR if parity is enabled, otherwise go to DONE.
- PAR: `ser_out` = parity bit, held DIV cycles; `ser_valid`=1; then go to DONE.
- DONE: `done`=1, `ser_valid`=0, `load_ready`=0; go to IDLE on the next cycle.
- Select counter: 3-bit. It never wraps inside a frame; it is cleared on accept and on reset.
- While not in IDLE, `load_valid` is ignored and `din` is not sampled.
- Reset outputs: `load_ready`=0 during reset and 1 in the first cycle after it; `a`=`b`=`c`=0; `ser_out`=0; `ser_valid`=0; `busy`=0; `done`=0. `data_q` resets to 0.
- Reset mid-frame: the frame is abandoned with no `done` pulse. The next cycle is IDLE.
- Outside SEND and PAR, `ser_out` is forced to 0.

## Timing
- An accept on edge k is cycle 0. Bit n is on `ser_out` during cycles 1+n·DIV through (n+1)·DIV.
- Without parity:
  - DONE in cycle 8·DIV+1.
  - `load_ready`=1 again in cycle 8·DIV+2.
  - Minimum frame-to-frame spacing is 8·DIV+2 cycles.
- With parity: PAR occupies cycles 8·DIV+1 through 9·DIV. DONE and the return to IDLE shift later by DIV.
- State, counters and `data_q` are registered. `ser_out` is combinational from registered `{a,b,c}` and `data_q` through the mux, and is therefore glitch-free relative to `clk`.
- `load_valid` held high continuously: a new word is accepted in the first IDLE cycle after DONE.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - PAR state present.
  - An even-parity bit (XOR of `data_q[7:0]`) is appended after bit 7, so the total count of 1s across 9 bits is even.
- Not defined: the PAR state and the parity logic are absent, and SEND goes directly to DONE.

## Structure
- Shared package `mux_scan_pkg`:
  - state enum (IDLE, SEND, PAR, DONE);
  - `SEL_W`=3;
  - `WORD_W`=8;
  - `DIV_W`=8.
- One sub-module: instantiate the existing `mux8_1`, with `d1..d8` = `data_q[0..7]`, `a`/`b`/`c` from the select counter, and `e` → `ser_out` path.
- No other hierarchy. The divider, select counter and FSM live in the top module.

## Test plan
- Reset, then `din`=8'h01, DIV=1, one-cycle `load_valid`:
  - `ser_out`=1 in cycle 1 and 0 in cycles 2–8;
  - `{a,b,c}` steps 0→7;
  - `done` in cycle 9;
  - `load_ready` in cycle 10.
- `din`=8'hA5, DIV=3: each bit is held 3 cycles, giving the sequence 1,0,1,0,0,1,0,1; `done` in cycle 25.
- `load_valid` held high with words 8'h3C then 8'hC3:
  - second accept occurs exactly at cycle 8·DIV+2;
  - `din` changes during SEND do not alter the stream.
- Assert `rst` during bit 4 of 8'hFF: the next cycle has all outputs 0 and no `done`; `load_ready` is 1 one cycle after reset releases.
- With `MUX_SCAN_PARITY_EN`:
  - 8'h07 → ninth bit 1;
  - 8'h03 → ninth bit 0;
  - `done` in cycle 10 (DIV=1).
- Without the macro: 8'h07 gives `done` in cycle 9 and no ninth bit (`ser_valid`=0 in cycle 9).
